// File: rtl/freq_gate_counter.sv
// Gated frequency counter: counts edge ticks over a window of GATE_CYCLES clocks
// and publishes the registered count with a one-cycle valid strobe and saturation flag.
//
// state | meaning
// IDLE  | not measuring; counters held at zero, ticks ignored
// GATE  | window open; gate_cnt runs 0..GATE_CYCLES-1, ticks accumulate
// LATCH | one dead cycle; result published, counters cleared, ticks ignored
module freq_gate_counter #(
    parameter int unsigned GATE_CYCLES = 50_000_000,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             enable,
    output logic [CNT_W-1:0] freq,
    output logic             freq_valid,
    output logic             freq_ovf,
    output logic             gate_active
);

    localparam int              GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0]   GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [GW-1:0]   GATE_ONE  = GW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GATE  = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] tick_cnt;
    logic             ovf_acc;
    logic             tick_max;
    logic [CNT_W-1:0] tick_sum;
    logic             ovf_sum;

    // Count including this cycle's tick, saturating at all-ones
    assign tick_max = &tick_cnt;
    assign tick_sum = (tick && !tick_max) ? tick_cnt + CNT_ONE : tick_cnt;
    assign ovf_sum  = ovf_acc | (tick & tick_max);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = GATE;
            GATE: begin
                if (!enable)                    state_nxt = IDLE;
                else if (gate_cnt == GATE_LAST) state_nxt = LATCH;
            end
            LATCH:   state_nxt = enable ? GATE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gate_cnt    <= '0;
            tick_cnt    <= '0;
            ovf_acc     <= 1'b0;
            freq        <= '0;
            freq_valid  <= 1'b0;
            freq_ovf    <= 1'b0;
            gate_active <= 1'b0;
        end else begin
            state       <= state_nxt;
            gate_active <= (state_nxt == GATE);
            freq_valid  <= 1'b0;
            if (state == GATE && state_nxt == GATE) begin
                gate_cnt <= gate_cnt + GATE_ONE;
                tick_cnt <= tick_sum;
                ovf_acc  <= ovf_sum;
            end else begin
                gate_cnt <= '0;
                tick_cnt <= '0;
                ovf_acc  <= 1'b0;
            end
            // An abort (enable low in GATE) leaves the previous result untouched
            if (state == GATE && state_nxt == LATCH) begin
                freq       <= tick_sum;
                freq_ovf   <= ovf_sum;
                freq_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_freq_gate_counter.sv
// Directed bench for freq_gate_counter: two instances (10/8 and 20/4) exercise
// window timing, boundary ticks, abort, mid-window reset and saturation.
module tb_freq_gate_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_a, en_a, tick_b, en_b;
    logic [7:0] freq_a;
    logic [3:0] freq_b;
    logic       valid_a, ovf_a, gact_a;
    logic       valid_b, ovf_b, gact_b;

    int n_chk  = 0;
    int n_err  = 0;
    int cyc    = 0;
    int last_v = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    freq_gate_counter #(.GATE_CYCLES(10), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .tick(tick_a), .enable(en_a),
        .freq(freq_a), .freq_valid(valid_a), .freq_ovf(ovf_a), .gate_active(gact_a)
    );

    freq_gate_counter #(.GATE_CYCLES(20), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .tick(tick_b), .enable(en_b),
        .freq(freq_b), .freq_valid(valid_b), .freq_ovf(ovf_b), .gate_active(gact_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] get_freq(input bit sel);
        return sel ? 32'(freq_b) : 32'(freq_a);
    endfunction
    function automatic logic get_valid(input bit sel);
        return sel ? valid_b : valid_a;
    endfunction
    function automatic logic get_ovf(input bit sel);
        return sel ? ovf_b : ovf_a;
    endfunction
    function automatic logic get_gact(input bit sel);
        return sel ? gact_b : gact_a;
    endfunction

    task automatic drive(input bit sel, input logic t, input logic e);
        if (sel) begin tick_b = t; en_b = e; end
        else     begin tick_a = t; en_a = e; end
    endtask

    // Entered in gate cycle 0; leaves one cycle after LATCH
    task automatic run_window(input string tag, input bit sel, input int n,
                              input logic [31:0] mask, input logic tick_latch,
                              input logic en_latch, input logic [31:0] exp_freq,
                              input logic exp_ovf, input bit chk_period);
        for (int k = 0; k < n; k++) begin
            drive(sel, mask[k], 1'b1);
            check({tag, " gate_active"}, 32'(get_gact(sel)), 32'd1);
            check({tag, " no_early_valid"}, 32'(get_valid(sel)), 32'd0);
            step();
        end
        drive(sel, tick_latch, en_latch);
        check({tag, " valid"}, 32'(get_valid(sel)), 32'd1);
        check({tag, " freq"}, get_freq(sel), exp_freq);
        check({tag, " ovf"}, 32'(get_ovf(sel)), 32'(exp_ovf));
        check({tag, " latch_gate_low"}, 32'(get_gact(sel)), 32'd0);
        if (chk_period) check({tag, " period"}, 32'(cyc - last_v), 32'd11);
        last_v = cyc;
        step();
        drive(sel, 1'b0, en_latch);
        check({tag, " valid_one_cycle"}, 32'(get_valid(sel)), 32'd0);
        check({tag, " next_gate"}, 32'(get_gact(sel)), 32'(en_latch));
        check({tag, " freq_held"}, get_freq(sel), exp_freq);
    endtask

    initial begin
        rst_n = 1'b0;
        tick_a = 1'b0; en_a = 1'b0; tick_b = 1'b0; en_b = 1'b0;
        repeat (3) step();
        check("rst freq_a", get_freq(0), 0);
        check("rst valid_a", 32'(valid_a), 0);
        check("rst ovf_a", 32'(ovf_a), 0);
        check("rst gact_a", 32'(gact_a), 0);
        check("rst freq_b", get_freq(1), 0);
        check("rst gact_b", 32'(gact_b), 0);

        rst_n = 1'b1;
        step();
        check("idle gact_a", 32'(gact_a), 0);
        en_a = 1'b1;
        step();

        // Three back-to-back windows: every-3rd ticks, boundary ticks + LATCH tick, then every-3rd again
        run_window("w1_every3", 0, 10, 32'h249, 1'b0, 1'b1, 4, 1'b0, 1'b0);
        run_window("w2_boundary", 0, 10, 32'h201, 1'b1, 1'b1, 2, 1'b0, 1'b1);
        run_window("w3_every3", 0, 10, 32'h249, 1'b0, 1'b1, 4, 1'b0, 1'b1);

        // Abort at gate cycle 5 with ticks pending
        for (int k = 0; k < 5; k++) begin
            drive(0, 1'b1, 1'b1);
            step();
        end
        drive(0, 1'b0, 1'b0);
        step();
        check("abort gact", 32'(gact_a), 0);
        check("abort no_valid", 32'(valid_a), 0);
        check("abort freq_kept", get_freq(0), 4);
        for (int k = 0; k < 3; k++) begin
            step();
            check("abort idle_valid", 32'(valid_a), 0);
        end
        en_a = 1'b1;
        step();
        run_window("after_abort", 0, 10, 32'h3FF, 1'b0, 1'b1, 10, 1'b0, 1'b0);

        // Reset at gate cycle 6 with tick_cnt=3
        for (int k = 0; k < 6; k++) begin
            drive(0, (k % 2 == 0) ? 1'b1 : 1'b0, 1'b1);
            step();
        end
        tick_a = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst freq", get_freq(0), 0);
        check("midrst gact", 32'(gact_a), 0);
        check("midrst valid", 32'(valid_a), 0);
        check("midrst ovf", 32'(ovf_a), 0);
        step();
        check("midrst held", 32'(gact_a), 0);
        rst_n = 1'b1;
        step();
        run_window("post_rst", 0, 10, 32'h001, 1'b0, 1'b0, 1, 1'b0, 1'b0);

        // Saturation on the 4-bit instance, then a clean empty window; enable dropped in LATCH
        en_b = 1'b1;
        step();
        run_window("sat", 1, 20, 32'hFFFFF, 1'b1, 1'b1, 15, 1'b1, 1'b0);
        run_window("empty", 1, 20, 32'h0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        step();
        check("final idle_b", 32'(gact_b), 0);
        check("final idle_a", 32'(gact_a), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/freq_gate_counter.md
Name: freq_gate_counter

Overview:
- Gated frequency counter that sits directly downstream of the edge detector in the frequency-measurement path (rtl/freq).
- Consumes the detector's single-cycle edge tick and counts ticks over a fixed gate window of GATE_CYCLES clocks.
- Publishes the count as a registered measurement with a one-cycle valid strobe and an overflow flag.
- With GATE_CYCLES equal to the clock frequency, the result is the input frequency in Hz; the display/readout logic consumes it.

Parameters:
- GATE_CYCLES, 50000000, gate window length in clk cycles; legal range 2 to 2^32-1.
- CNT_W, 32, width of the tick counter and the freq output.

Ports:
- clk  input  1  system clock; the only clock.
- rst_n  input  1  asynchronous active-low reset.
- tick  input  1  one-cycle edge pulse from the edge detector; synchronous to clk.
- enable  input  1  level; high = measure continuously, low = stop.
- freq  output  CNT_W  last completed measurement (tick count in the window).
- freq_valid  output  1  one-cycle strobe; freq was updated this cycle.
- freq_ovf  output  1  last measurement saturated; updated together with freq.
- gate_active  output  1  high while the gate window is open (state GATE).

Behaviour:
- Reset is asynchronous, active-low, and applies to all registers:
  - state = IDLE, gate_cnt = 0, tick_cnt = 0, ovf_acc = 0.
  - freq = 0, freq_valid = 0, freq_ovf = 0, gate_active = 0.
- All outputs are registered.
- gate_active is high exactly when state == GATE.
- FSM has states IDLE, GATE, LATCH.
- IDLE:
  - gate_cnt, tick_cnt and ovf_acc are held at 0.
  - tick is ignored.
  - enable == 1 moves to GATE on the next edge.
- GATE:
  - The window is exactly GATE_CYCLES consecutive cycles. gate_cnt counts 0 .. GATE_CYCLES-1, incrementing by 1 per cycle.
  - Every cycle in GATE with tick == 1 increments tick_cnt by 1, including the first and last gate cycle.
  - When gate_cnt == GATE_CYCLES-1, the final tick of that cycle is included and the next state is LATCH.
  - On that same edge: freq <= final count, freq_ovf <= final ovf_acc, freq_valid <= 1.
- Saturation:
  - tick_cnt holds at 2^CNT_W-1 on further ticks; it does not wrap.
  - An increment attempted at the maximum sets ovf_acc = 1.
- LATCH (exactly one cycle):
  - freq_valid is high in this cycle only.
  - gate_cnt, tick_cnt and ovf_acc clear to 0.
  - tick is ignored; this is the dead cycle between windows.
  - Next state: GATE if enable == 1, else IDLE.
- Back-to-back measurement period is GATE_CYCLES+1 clocks.
- enable deasserted during GATE:
  - Abort: next state IDLE, counters clear, no freq_valid.
  - freq and freq_ovf keep the previous measurement.
- enable deasserted during LATCH: the measurement still completes (valid pulse issued), then IDLE.
- enable re-asserted in IDLE: a fresh full window starts; partial windows are never reported.
- freq_valid is never high for two consecutive cycles.
- freq changes only on the edge that raises freq_valid.
- Reset asserted mid-window: all state returns to reset values immediately, freq = 0, no valid pulse.
- tick high for multiple consecutive cycles counts once per cycle. The block does not re-detect edges; upstream guarantees pulses.

Test Plan:
- GATE_CYCLES=10, CNT_W=8, enable=1, tick every 3rd cycle starting at gate cycle 0 -> freq_valid one cycle after cycle 9 of the window, freq=4, freq_ovf=0; next window opens in the following cycle.
- GATE_CYCLES=10, ticks only on gate cycle 0 and gate cycle 9, plus a tick during LATCH -> freq=2 (boundary ticks counted, LATCH tick dropped).
- GATE_CYCLES=20, CNT_W=4, tick held high continuously -> freq=15, freq_ovf=1; next window with no ticks -> freq=0, freq_ovf=0.
- GATE_CYCLES=10, previous freq=4, drop enable at gate cycle 5 -> gate_active falls, no freq_valid, freq stays 4; re-assert enable -> full 10-cycle window, new valid pulse.
- Assert rst_n low at gate cycle 6 with tick_cnt=3 -> outputs immediately 0, state IDLE; after release with enable=1 -> window restarts from gate_cnt=0.
- Continuous enable, 3 windows of 10 -> freq_valid pulses exactly 11 cycles apart, each one cycle wide.
